// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: default widths, the host starvation limit and
// the tag that rides alongside each VRAM access through the read pipeline.
package vga_pkg;

    localparam int VRAM_ADDR_W      = 17;
    localparam int PIXEL_W          = 12;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        TAG_NONE    = 2'd0,
        TAG_DISP    = 2'd1,
        TAG_HOST_RD = 2'd2
    } access_tag_e;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port synchronous VRAM between display scan-out (fixed
// priority) and a host port that is force-granted after STARVE_LIMIT blocked cycles.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = PIXEL_W,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;
    access_tag_e      r_tag_s1;
    access_tag_e      r_tag_s2;

    logic             w_force_host;
    logic             w_xfer;
    access_tag_e      w_tag_in;

    // Grants are combinational so a requester sees its transfer in the same cycle.
    assign w_force_host = (r_starve_cnt == CNT_MAX);
    assign disp_gnt     = !reset && disp_req && !w_force_host;
    assign host_gnt     = !reset && host_req && (!disp_req || w_force_host);
    assign w_xfer       = disp_gnt || host_gnt;

    always_comb begin
        w_tag_in = TAG_NONE;
        if (disp_gnt)
            w_tag_in = TAG_DISP;
        else if (host_gnt && !host_we)
            w_tag_in = TAG_HOST_RD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_starve_cnt <= '0;
        else if (!host_req || host_gnt)
            r_starve_cnt <= '0;
        else if (!w_force_host)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

    // Stage 1 drives the VRAM; stage 2 lines up with mem_rdata; then the result port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            r_tag_s1    <= TAG_NONE;
            r_tag_s2    <= TAG_NONE;
            disp_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            disp_rdata  <= '0;
            host_rdata  <= '0;
        end else begin
            mem_en   <= w_xfer;
            mem_we   <= host_gnt && host_we;
            if (disp_gnt)
                mem_addr <= disp_addr;
            else if (host_gnt)
                mem_addr <= host_addr;
            if (host_gnt)
                mem_wdata <= host_wdata;

            r_tag_s1    <= w_tag_in;
            r_tag_s2    <= r_tag_s1;
            disp_rvalid <= (r_tag_s2 == TAG_DISP);
            host_rvalid <= (r_tag_s2 == TAG_HOST_RD);
            if (r_tag_s2 == TAG_DISP)
                disp_rdata <= mem_rdata;
            if (r_tag_s2 == TAG_HOST_RD)
                host_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: per-cycle grant/memory-port model plus a
// scoreboard of expected read returns (port, data, due cycle) in grant order.
module tb_vram_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int LIMIT = 8;

    localparam logic [1:0] T_DISP = 2'd1;
    localparam logic [1:0] T_HOST = 2'd2;

    logic          clk;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_gnt   (disp_gnt),
        .disp_rdata (disp_rdata),
        .disp_rvalid(disp_rvalid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Memory contents: VRAM behaviour model and the bench's own shadow for expectations.
    logic [DW-1:0] vram   [logic [AW-1:0]];
    logic [DW-1:0] shadow [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 12'h3C5;
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : init_pat(a);
    endfunction

    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                vram[mem_addr] = mem_wdata;
            else
                mem_rdata <= vram.exists(mem_addr) ? vram[mem_addr] : init_pat(mem_addr);
        end
    end

    typedef struct {
        logic [1:0]    tag;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q[$];

    int            m_cnt;
    logic          p_en, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] last_d, last_h;

    always @(negedge clk) begin
        logic e_force, e_dg, e_hg, e_dv, e_hv;
        if (reset) begin
            m_cnt   = 0;
            p_en    = 1'b0;
            p_we    = 1'b0;
            p_addr  = '0;
            p_wdata = '0;
            last_d  = '0;
            last_h  = '0;
            q.delete();
        end else begin
            e_force = (m_cnt == LIMIT);
            e_dg    = disp_req && !e_force;
            e_hg    = host_req && (!disp_req || e_force);
            check_eq("disp_gnt", disp_gnt, e_dg);
            check_eq("host_gnt", host_gnt, e_hg);

            check_eq("mem_en", mem_en, p_en);
            check_eq("mem_we", mem_we, p_we);
            check_eq("mem_addr", mem_addr, p_addr);
            check_eq("mem_wdata", mem_wdata, p_wdata);

            e_dv = 1'b0;
            e_hv = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.tag == T_DISP) begin
                    e_dv   = 1'b1;
                    last_d = e.data;
                end else begin
                    e_hv   = 1'b1;
                    last_h = e.data;
                end
            end
            check_eq("disp_rvalid", disp_rvalid, e_dv);
            check_eq("host_rvalid", host_rvalid, e_hv);
            check_eq("disp_rdata", disp_rdata, last_d);
            check_eq("host_rdata", host_rdata, last_h);

            if (e_dg)
                q.push_back('{tag: T_DISP, data: shadow_rd(disp_addr), due: cyc + 3});
            if (e_hg && !host_we)
                q.push_back('{tag: T_HOST, data: shadow_rd(host_addr), due: cyc + 3});
            if (e_hg && host_we)
                shadow[host_addr] = host_wdata;

            p_en = e_dg || e_hg;
            p_we = e_hg && host_we;
            if (e_dg)
                p_addr = disp_addr;
            else if (e_hg)
                p_addr = host_addr;
            if (e_hg)
                p_wdata = host_wdata;

            if (host_req && !e_hg)
                m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : m_cnt;
            else
                m_cnt = 0;
        end
    end

    task automatic drive(input logic dr, input logic [AW-1:0] da, input logic hr,
                         input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        disp_req   = dr;
        disp_addr  = da;
        host_req   = hr;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, disp_addr, 1'b0, host_we, host_addr, host_wdata);
    endtask

    initial begin
        reset      = 1'b1;
        disp_req   = 1'b0;
        disp_addr  = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        vram[17'h00010]   = 12'hABC;
        shadow[17'h00010] = 12'hABC;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_en", mem_en, 1'b0);
        check_eq("rst_mem_addr", mem_addr, '0);
        disp_req = 1'b1;
        host_req = 1'b1;
        #1;
        check_eq("rst_disp_gnt", disp_gnt, 1'b0);
        check_eq("rst_host_gnt", host_gnt, 1'b0);
        disp_req = 1'b0;
        host_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Single display read of a preloaded pixel.
        drive(1'b1, 17'h00010, 1'b0, 1'b0, '0, '0);
        idle(5);

        // Host write to the top address, then read it back.
        drive(1'b0, '0, 1'b1, 1'b1, 17'h1FFFF, 12'h5A5);
        idle(2);
        drive(1'b0, '0, 1'b1, 1'b0, 17'h1FFFF, '0);
        idle(5);

        // Uncontended host reads.
        for (int i = 0; i < 3; i++)
            drive(1'b0, '0, 1'b1, 1'b0, AW'(17'h00400 + i), '0);
        idle(5);

        // Continuous contention: host forced through every 9th cycle.
        for (int i = 0; i < 30; i++) begin
            disp_req   = 1'b1;
            disp_addr  = AW'(17'h00100 + i);
            host_req   = 1'b1;
            host_we    = 1'b0;
            host_addr  = AW'(17'h00200 + i);
            #2;
            check_eq("starve_pattern", host_gnt, (i % 9) == 8);
            @(posedge clk);
            #1;
        end
        idle(5);

        // Back-to-back disp, host, disp reads.
        drive(1'b1, 17'h00020, 1'b0, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, 17'h1FFFF, '0);
        drive(1'b1, 17'h00010, 1'b0, 1'b0, '0, '0);
        idle(6);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 63)), DW'($urandom));
        idle(6);

        // Reset while a display read is in flight.
        drive(1'b1, 17'h00033, 1'b0, 1'b0, '0, '0);
        disp_req = 1'b0;
        #2;
        check_eq("pre_rst_mem_en", mem_en, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_mem_en", mem_en, 1'b0);
        check_eq("async_rst_mem_addr", mem_addr, '0);
        check_eq("async_rst_disp_rdata", disp_rdata, '0);
        check_eq("async_rst_host_rdata", host_rdata, '0);
        check_eq("async_rst_mem_wdata", mem_wdata, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(6);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            idle(1);
        check_eq("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, meaning VRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 12, meaning pixel word width (4-bit R/G/B).
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, meaning max consecutive host-blocked cycles before host is forced.
REQ-004 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: disp_req in 1, disp_addr in ADDR_W, disp_gnt out 1, disp_rdata out DATA_W, disp_rvalid out 1; the display scan-out read port.
REQ-007 SHALL have ports: host_req in 1, host_we in 1, host_addr in ADDR_W, host_wdata in DATA_W, host_gnt out 1, host_rdata out DATA_W, host_rvalid out 1; the host read/write port.
REQ-008 SHALL have ports: mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W; the single-port synchronous VRAM, read data valid the cycle after mem_en.

Function
REQ-009 SHALL define a transfer as req && gnt high in the same cycle; gnt is combinational from req and registered state.
REQ-010 SHALL grant at most one requester per cycle.
REQ-011 SHALL give display fixed priority: disp_gnt = disp_req && !force_host.
REQ-012 SHALL assert host_gnt = host_req && (!disp_req || force_host).
REQ-013 SHALL keep an internal starvation counter: increments when host_req && !host_gnt, clears on host transfer or when host_req low, saturates at STARVE_LIMIT.
REQ-014 SHALL assert force_host when counter == STARVE_LIMIT; cleared by the resulting host transfer.
REQ-015 SHALL register mem_en, mem_we, mem_addr, mem_wdata one cycle after the transfer (transfer cycle N -> mem access N+1).
REQ-016 SHALL drive mem_en = 0, mem_we = 0 in any cycle following a no-transfer cycle; mem_addr/mem_wdata hold last value.
REQ-017 SHALL carry a 2-bit tag (NONE, DISP, HOST_RD) alongside each access through a 2-stage pipeline.
REQ-018 SHALL capture mem_rdata at N+2 and present it registered at N+3 on the tagged port's rdata with a one-cycle rvalid pulse.
REQ-019 SHALL generate no rvalid for host writes (tag NONE).
REQ-020 SHALL hold disp_rdata/host_rdata stable between rvalid pulses.
REQ-021 SHALL sustain one transfer per cycle with back-to-back requests; read data returns in grant order.
REQ-022 SHALL, when disp_req and host_req are simultaneous and force_host is high, grant host and leave disp_req blocked that cycle.
REQ-023 SHALL ignore host_we, host_addr, host_wdata in cycles without host transfer.

Reset
REQ-024 SHALL, on reset assertion, immediately clear mem_en, mem_we, mem_addr, mem_wdata, disp_rvalid, host_rvalid, disp_rdata, host_rdata, starvation counter, and all pipeline tags to 0/NONE.
REQ-025 SHALL discard in-flight reads on reset: no rvalid pulse for any transfer issued before reset.
REQ-026 SHALL force gnt outputs low while reset is high.

Structure
REQ-027 SHALL place ADDR_W/DATA_W defaults, STARVE_LIMIT default, and the tag enumeration in the shared package vga_pkg.
REQ-028 SHALL be a single module; no sub-module required.

Verification
REQ-029 SHALL cover: disp_req=1 with disp_addr=0x00010 for one cycle, mem_rdata=0xABC at next cycle -> mem_en=1 with mem_addr=0x00010 at N+1, disp_rvalid=1 with disp_rdata=0xABC at N+3.
REQ-030 SHALL cover: host write host_we=1, host_addr=0x1FFFF, host_wdata=0x5A5 with disp_req low -> mem_we=1, mem_addr=0x1FFFF, mem_wdata=0x5A5 at N+1, no host_rvalid.
REQ-031 SHALL cover: disp_req and host_req held high continuously -> host_gnt low for 8 cycles, high on 9th cycle, disp_gnt low that cycle, then pattern repeats.
REQ-032 SHALL cover: alternating disp read, host read, disp read back-to-back -> rvalids in order disp, host, disp at N+3, N+4, N+5 with matching data.
REQ-033 SHALL cover: reset asserted at N+1 of an outstanding disp read -> outputs zero asynchronously, no disp_rvalid after reset release.
REQ-034 SHALL cover: host_req high, disp_req low -> host_gnt high same cycle, starvation counter stays 0.
